// File: rtl/digit_scroller_pkg.sv
// digit_scroller_pkg: shared widths, default rate and counter-width helper
package digit_scroller_pkg;
  localparam int DIGIT_W = 4;
  localparam int TICK_DIV_50MHZ_HALF_S = 25000000;
  function automatic int cw(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/digit_scroller_tick_gen.sv
// tick_gen: enabled prescaler with synchronous clear and terminal-count pulse
module tick_gen
  import digit_scroller_pkg::*;
#(
  parameter int DIV = TICK_DIV_50MHZ_HALF_S
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int W = cw(DIV);
  logic [W-1:0] cnt;
  // terminal count only counts while enabled, so a paused counter never fires
  always_comb tc = en && (cnt == W'(DIV - 1));
  // count 0..DIV-1, hold while disabled, clear has priority over counting
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/digit_scroller.sv
// digit_scroller: rotating window over a loaded digit sequence; optional DIGIT_SCROLLER_MANUAL_STEP_EN adds step_req
module digit_scroller
  import digit_scroller_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SEQ_LEN = 8,
  parameter int TICK_DIV = TICK_DIV_50MHZ_HALF_S
) (
  input  logic clk,
  input  logic rst,
  input  logic [DIGIT_W*SEQ_LEN-1:0] seq_data,
  input  logic load,
  input  logic run,
  input  logic dir,
`ifdef DIGIT_SCROLLER_MANUAL_STEP_EN
  input  logic step_req,
`endif
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic [3:0] pos,
  output logic tick
);
  logic [DIGIT_W*SEQ_LEN-1:0] seq_reg, seq_n;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits_n;
  logic [3:0] pos_n;
  logic tick_n, tc, step;
  tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .en(run), .clr(load), .tc(tc));
  // next sequence/position, then the window is built from those so digits always matches pos
  always_comb begin
`ifdef DIGIT_SCROLLER_MANUAL_STEP_EN
    step = tc || (!run && step_req);
`else
    step = tc;
`endif
    seq_n = load ? seq_data : seq_reg;
    tick_n = !load && step;
    pos_n = load ? 4'd0 : !step ? pos : dir ? (pos == 4'd0 ? 4'(SEQ_LEN - 1) : pos - 4'd1) : (pos == 4'(SEQ_LEN - 1) ? 4'd0 : pos + 4'd1);
    digits_n = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      for (int j = 0; j < SEQ_LEN; j++)
        if ((int'(pos_n) + k) % SEQ_LEN == j) digits_n[k*DIGIT_W +: DIGIT_W] = seq_n[j*DIGIT_W +: DIGIT_W];
  end
  // all outputs registered
  always_ff @(posedge clk)
    if (rst) begin
      seq_reg <= '0;
      pos <= '0;
      digits <= '0;
      tick <= 1'b0;
    end else begin
      seq_reg <= seq_n;
      pos <= pos_n;
      digits <= digits_n;
      tick <= tick_n;
    end
endmodule
